// File: rtl/aes_pkg.sv
// Shared AES-128 encryption tables, GF(2^8) helpers and FSM encoding used by
// the iterative encryptor and its round datapath.
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  // Forward S-box; element 0 sits in the most significant byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Rounds are numbered 1..10; anything else yields no round constant.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'd10) return RCON[round - 4'd1];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round plus the matching on-the-fly
// key-schedule step; MixColumns is skipped for the final round.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] rk,
  input  logic [3:0]         round,
  output logic [BLOCK_W-1:0] next_state,
  output logic [BLOCK_W-1:0] next_rk
);

  logic [7:0]         sb [16];
  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] mixed;
  logic [31:0]        t, w4, w5, w6, w7;

  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(state[127-8*i -: 8]);
    // Byte i is row i%4, column i/4; row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[127-8*(r+4*c) -: 8] = sb[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);

    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
         ^ {rcon(round), 24'h0};
    w4 = rk[127:96] ^ t;
    w5 = rk[95:64] ^ w4;
    w6 = rk[63:32] ^ w5;
    w7 = rk[31:0] ^ w6;
    next_rk = {w4, w5, w6, w7};

    next_state = ((round == 4'(NR)) ? shifted : mixed) ^ next_rk;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock after the initial
// AddRoundKey, ciphertext returned over a valid/ready handshake.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter bit ZERO_OUT = 1'b1
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [BLOCK_W-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] data_out
);

  fsm_t               fsm, fsm_n;
  logic [BLOCK_W-1:0] state_q, rk_q, next_state, next_rk;
  logic [3:0]         round_q;

  aes_round_comb u_round (
    .state      (state_q),
    .rk         (rk_q),
    .round      (round_q),
    .next_state (next_state),
    .next_rk    (next_rk)
  );

  always_comb begin
    fsm_n = fsm;
    case (fsm)
      IDLE:    if (in_valid) fsm_n = RUN;
      RUN:     if (round_q == 4'(NR)) fsm_n = DONE;
      DONE:    if (out_ready) fsm_n = IDLE;
      default: fsm_n = IDLE;
    endcase
  end

  // The counter saturates at NR through the last round and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= 4'd0;
    end else begin
      fsm <= fsm_n;
      case (fsm)
        IDLE: if (in_valid) begin
          state_q <= plaintext ^ key;
          rk_q    <= key;
          round_q <= 4'd1;
        end
        RUN: begin
          state_q <= next_state;
          rk_q    <= next_rk;
          if (round_q != 4'(NR)) round_q <= round_q + 4'd1;
        end
        DONE: if (out_ready) round_q <= 4'd0;
        default: round_q <= 4'd0;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE) && !rst;
  assign out_valid = (fsm == DONE);
  assign data_out  = (ZERO_OUT && !out_valid) ? '0 : state_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for aes_encrypt_iter: known-answer vectors, latency,
// back-pressure, mid-run reset and random blocks against an abstract AES model.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         in_ready, out_valid;
  logic [127:0] data_out;
  logic         in_ready_h, out_valid_h;
  logic [127:0] data_out_h;

  int nCompared   = 0;
  int nMismatched = 0;
  int cycle       = 0;
  logic [127:0] sbQ[$];
  logic [7:0]   refSbox [256];

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_R1  = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out)
  );

  // Second instance exposes the raw state register through data_out.
  aes_encrypt_iter #(.ZERO_OUT(1'b0)) dut_hold (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
    .plaintext(plaintext), .key(key), .out_valid(out_valid_h),
    .out_ready(out_ready), .data_out(data_out_h)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its algebraic definition: GF(2^8) inverse then affine map.
  task automatic buildRefSbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      refSbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] refEncrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {refSbox[tmp[31:24]], refSbox[tmp[23:16]], refSbox[tmp[15:8]], refSbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = refSbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r + 4*((c + r) % 4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rnd < 10)
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r+4*c] = gmul(8'h02, s[r+4*c]) ^ gmul(8'h03, s[(r+1)%4+4*c])
                       ^ s[(r+2)%4+4*c] ^ s[(r+3)%4+4*c];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair, waits for in_ready, scores it, and returns after the accept edge.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k,
                               input bit keepValid, output int acceptCycle);
    int n;
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 128'(n), 128'd0);
    sbQ.push_back(refEncrypt(pt, k));
    step();
    acceptCycle = cycle;
    if (!keepValid) in_valid = 1'b0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    key       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic waitValid(output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!out_valid && edges < 20);
  endtask

  always @(negedge clk) begin
    logic [127:0] expv;
    if (!rst && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_output: got %h expected none", data_out);
      end else begin
        expv = sbQ.pop_front();
        checkOutput("scoreboard", data_out, expv);
      end
    end
  end

  initial begin
    int edges, acc, prevAcc, stray;
    logic busyBad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    buildRefSbox();
    repeat (2) step();
    checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_data_out", data_out_h, 128'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 128'(in_ready), 128'd1);

    // App. B with latency and back-pressure
    applyStimulus(B_PT, B_KEY, 1'b0, acc);
    waitValid(edges);
    checkOutput("appB_latency", 128'(edges), 128'd10);
    checkOutput("appB_data", data_out, B_CT);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("bp_valid", 128'(out_valid), 128'd1);
      checkOutput("bp_data", data_out, B_CT);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp_release_valid", 128'(out_valid), 128'd0);
    checkOutput("bp_release_in_ready", 128'(in_ready), 128'd1);
    checkOutput("zero_out_idle", data_out, 128'd0);

    // App. C.1 round-1 state, then reset in the middle of the run
    applyStimulus(C_PT, C_KEY, 1'b0, acc);
    step();
    checkOutput("appC_round1", data_out_h, C_R1);
    checkOutput("zero_out_run", data_out, 128'd0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("midreset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("midreset_data_out", data_out_h, 128'd0);
    checkOutput("midreset_in_ready", 128'(in_ready), 128'd1);
    stray = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (out_valid) stray++;
    end
    checkOutput("midreset_no_output", 128'(stray), 128'd0);

    out_ready = 1'b1;
    applyStimulus(B_PT, B_KEY, 1'b0, acc);
    waitValid(edges);
    checkOutput("appB_after_reset", data_out, B_CT);
    step();
    out_ready = 1'b0;

    // All-zero vector with in_valid held through RUN and DONE
    applyStimulus('0, '0, 1'b1, acc);
    busyBad = 1'b0;
    edges = 0;
    do begin
      step();
      edges++;
      if (!out_valid && in_ready) busyBad = 1'b1;
    end while (!out_valid && edges < 20);
    checkOutput("zero_latency", 128'(edges), 128'd10);
    repeat (3) step();
    checkOutput("zero_done_in_ready", 128'(in_ready), 128'd0);
    checkOutput("zero_run_in_ready", 128'(busyBad), 128'd0);
    checkOutput("zero_data", data_out, Z_CT);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("no_same_edge_accept", 128'(in_ready), 128'd1);
    step();
    checkOutput("still_idle", 128'(in_ready), 128'd1);

    // Back-to-back random blocks with both handshakes tied high
    out_ready = 1'b1;
    prevAcc = 0;
    for (int t = 0; t < 3; t++) begin
      applyStimulus({$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom}, 1'b1, acc);
      if (t > 0) checkOutput("b2b_spacing", 128'(acc - prevAcc), 128'd12);
      prevAcc = acc;
    end
    in_valid = 1'b0;
    repeat (12) step();
    out_ready = 1'b0;

    // Random blocks with random back-pressure
    for (int t = 0; t < 4; t++) begin
      applyStimulus({$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
      waitValid(edges);
      checkOutput("rand_latency", 128'(edges), 128'd10);
      repeat ($urandom_range(0, 4)) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    edges = 0;
    while (sbQ.size() != 0 && edges < 30) begin
      step();
      edges++;
    end
    checkOutput("scoreboard_drain", 128'(sbQ.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
